ram_16x128_dp: RTL and testbench
================================

// Module: ram_16x128_dp
// PURPOSE
//  - True dual-port synchronous RAM: 128 words x 16 bits, two independent read/write ports (A, B).
//  - Both ports share a single clock.
//  - Backing store for the Layer-2 counter-sum tables of the tree sketch.
//  - A writer stores one summed counter per address. Either port reads it back with 1-cycle latency.
// PARAMETERS
//  - DATA_WIDTH  16   word width in bits
//  - ADDR_WIDTH  7    address width in bits
//  - DEPTH       128  number of words; must equal 2**ADDR_WIDTH
// PORTS
//  - Clk        in   1           single clock, rising edge
//  - Reset_n    in   1           asynchronous active-low reset
//  - ena        in   1           port A enable (gates read and write)
//  - wea        in   1           port A write enable, qualified by ena
//  - addra      in   ADDR_WIDTH  port A address
//  - dina       in   DATA_WIDTH  port A write data
//  - douta      out  DATA_WIDTH  port A read data (registered)
//  - enb        in   1           port B enable
//  - web        in   1           port B write enable, qualified by enb
//  - addrb      in   ADDR_WIDTH  port B address
//  - dinb       in   DATA_WIDTH  port B write data
//  - doutb      out  DATA_WIDTH  port B read data (registered)
//  - init_done  out  1           high once the post-reset clear sweep has finished
// BEHAVIOUR
//  Reset and clear sweep
//  - Reset_n low (async): douta=0, doutb=0, init_done=0, internal sweep address=0.
//  - After release, one word per cycle is zeroed, address 0..127: 128 cycles.
//  - init_done rises on the cycle after address 127 is cleared.
//  - While init_done=0, ena/enb are ignored: no writes, douta/doutb held at 0.
//  - Reset asserted mid-sweep or mid-operation restarts the sweep from 0 and zeroes outputs immediately.
//  Access (init_done=1), per port X in {A,B}
//  - enX=0: memory untouched, doutX holds its previous value.
//  - enX=1, weX=0: doutX <= mem[addrX] on the next edge (latency 1).
//  - enX=1, weX=1: mem[addrX] <= dinX. WRITE_FIRST: doutX <= dinX on the same edge.
//  Collisions (same address, same edge)
//  - Both ports write: port A data is stored; each port's dout shows its own din.
//  - One port writes, the other reads: the reader returns the OLD word (read-before-write across ports).
//  - Both ports read: both return the same word.
//  Arithmetic and edge cases
//  - No arithmetic. Addresses are full-range 0..127; no wrap or out-of-range case.
//  - Data is stored verbatim, all 16 bits.
// CONFIGURATION
//  - Macro RAM_16X128_OUTREG_EN.
//  - Defined: an extra output pipeline register is added on each port.
//    - Read latency becomes 2 cycles.
//    - The extra stage loads whenever the first stage was enabled on the previous cycle, else holds.
//    - Reset clears both stages.
//    - WRITE_FIRST data also appears after 2 cycles.
//  - Undefined: single-register output, latency 1 as above.
// TESTING
//  - Reset, then count cycles:
//    - init_done rises exactly 128 cycles after Reset_n release.
//    - Reads of addr 0, 64 and 127 return 16'h0000.
//  - Port A writes 16'hBEEF @7, then port B reads @7 the next cycle:
//    - doutb=16'hBEEF one cycle later (two cycles with RAM_16X128_OUTREG_EN).
//  - Same edge, A writes 16'h1234 @5 and B writes 16'h5678 @5; then read @5:
//    - Read returns 16'h1234.
//    - On the write edge, douta=16'h1234 and doutb=16'h5678.
//  - mem[9]=16'h0011; same edge, A writes 16'h00AA @9 while B reads @9:
//    - doutb=16'h0011.
//    - A later read of @9 returns 16'h00AA.
//  - enb=0 for 5 cycles after reading 16'hBEEF:
//    - doutb stays 16'hBEEF.
//    - Toggling web/dinb while enb=0 leaves memory unchanged.
//  - Reset_n pulsed low mid-traffic:
//    - douta/doutb go 0 asynchronously; init_done drops.
//    - After the sweep, previously written addresses read 16'h0000.

Source files
------------

// File: rtl/ram_16x128_dp_if.sv
// Port bundle for the 128x16 true dual-port RAM: per-port enable, write enable,
// address, write data and registered read data, plus the clear-sweep done flag.
interface ram_16x128_dp_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7
);
  logic                  ena;
  logic                  wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic [DATA_WIDTH-1:0] douta;

  logic                  enb;
  logic                  web;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] dinb;
  logic [DATA_WIDTH-1:0] doutb;

  logic                  init_done;

  modport master (
    output ena, wea, addra, dina,
    output enb, web, addrb, dinb,
    input  douta, doutb, init_done
  );

  modport slave (
    input  ena, wea, addra, dina,
    input  enb, web, addrb, dinb,
    output douta, doutb, init_done
  );
endinterface

// File: rtl/ram_16x128_dp.sv
// 128x16 true dual-port RAM, shared clock, post-reset clear sweep, WRITE_FIRST per port.
// Define RAM_16X128_OUTREG_EN to add a second output register per port (latency 2).
module ram_16x128_dp #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 128
) (
  input  logic            Clk,
  input  logic            Reset_n,
  ram_16x128_dp_if.slave  bus
);

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_sweep_addr;
  logic                  w_sweep_last;
  logic                  w_ready;

  logic                  w_en_a;
  logic                  w_en_b;
  logic                  w_wr_a;
  logic                  w_wr_b;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_douta;
  logic [DATA_WIDTH-1:0] r_doutb;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_SWEEP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sweep_last = (r_sweep_addr == ADDR_WIDTH'(DEPTH - 1));
    w_ready      = 1'b0;
    case (r_state)
      ST_SWEEP: if (w_sweep_last) w_state_nxt = ST_READY;
      ST_READY: w_ready = 1'b1;
      default:  w_state_nxt = ST_SWEEP;
    endcase
    w_en_a = w_ready & bus.ena;
    w_en_b = w_ready & bus.enb;
    w_wr_a = w_en_a & bus.wea;
    w_wr_b = w_en_b & bus.web;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sweep_addr <= '0;
    end else if (r_state == ST_SWEEP && !w_sweep_last) begin
      r_sweep_addr <= r_sweep_addr + ADDR_WIDTH'(1);
    end
  end

  // Port A is written after port B so it wins a same-address double write.
  always_ff @(posedge Clk) begin
    if (r_state == ST_SWEEP) begin
      r_mem[r_sweep_addr] <= '0;
    end else begin
      if (w_wr_b) r_mem[bus.addrb] <= bus.dinb;
      if (w_wr_a) r_mem[bus.addra] <= bus.dina;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_douta <= '0;
    end else if (w_en_a) begin
      r_douta <= bus.wea ? bus.dina : r_mem[bus.addra];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_doutb <= '0;
    end else if (w_en_b) begin
      r_doutb <= bus.web ? bus.dinb : r_mem[bus.addrb];
    end
  end

`ifdef RAM_16X128_OUTREG_EN
  logic                  r_en_a_d;
  logic                  r_en_b_d;
  logic [DATA_WIDTH-1:0] r_douta_q;
  logic [DATA_WIDTH-1:0] r_doutb_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_en_a_d  <= 1'b0;
      r_en_b_d  <= 1'b0;
      r_douta_q <= '0;
      r_doutb_q <= '0;
    end else begin
      r_en_a_d <= w_en_a;
      r_en_b_d <= w_en_b;
      if (r_en_a_d) r_douta_q <= r_douta;
      if (r_en_b_d) r_doutb_q <= r_doutb;
    end
  end

  assign bus.douta = r_douta_q;
  assign bus.doutb = r_doutb_q;
`else
  assign bus.douta = r_douta;
  assign bus.doutb = r_doutb;
`endif

  assign bus.init_done = (r_state == ST_READY);

endmodule

// File: tb/tb_ram_16x128_dp.sv
// Scoreboard bench for ram_16x128_dp: a behavioural memory model predicts each
// cycle's port outputs, a negedge monitor compares them when they fall due.
module tb_ram_16x128_dp;

`ifdef RAM_16X128_OUTREG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  typedef struct {
    int unsigned due;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  exp_t        sb[$];
  logic [15:0] ref_mem [128];
  logic [15:0] exp_a = '0;
  logic [15:0] exp_b = '0;

  ram_16x128_dp_if #(.DATA_WIDTH(16), .ADDR_WIDTH(7)) bus ();

  ram_16x128_dp #(.DATA_WIDTH(16), .ADDR_WIDTH(7), .DEPTH(128)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL stale_expect: got cycle %0d expected cycle %0d", cyc, e.due);
      end else begin
        check("douta", bus.douta, e.a);
        check("doutb", bus.doutb, e.b);
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    exp_a = '0;
    exp_b = '0;
    sb.delete();
  endtask

  // One access cycle on both ports; the model reads the pre-edge contents, then
  // applies B's write followed by A's so A wins a same-address collision.
  task automatic issue(input logic ea, input logic wa, input logic [6:0] aa, input logic [15:0] da,
                       input logic eb, input logic wb, input logic [6:0] ab, input logic [15:0] db);
    exp_t e;
    bus.ena = ea; bus.wea = wa; bus.addra = aa; bus.dina = da;
    bus.enb = eb; bus.web = wb; bus.addrb = ab; bus.dinb = db;
    if (ea) exp_a = wa ? da : ref_mem[aa];
    if (eb) exp_b = wb ? db : ref_mem[ab];
    if (eb && wb) ref_mem[ab] = db;
    if (ea && wa) ref_mem[aa] = da;
    e.due = cyc + LAT;
    e.a   = exp_a;
    e.b   = exp_b;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bus.ena = 1'b0;
    bus.enb = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    if (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0 pending", sb.size());
      sb.delete();
    end
  endtask

  // Release reset mid-cycle and hammer both ports during the sweep; none of it may land.
  task automatic sweep();
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 128; i++) begin
      bus.ena = 1'b1; bus.wea = 1'b1; bus.addra = 7'($urandom); bus.dina = 16'($urandom);
      bus.enb = 1'b1; bus.web = 1'b1; bus.addrb = 7'($urandom); bus.dinb = 16'($urandom);
      @(posedge clk); #1;
      if (i == 64) begin
        check("sweep_douta", bus.douta, 16'h0000);
        check("sweep_doutb", bus.doutb, 16'h0000);
      end
      if (i == 127) check("init_done_early", 16'(bus.init_done), 16'h0000);
      if (i == 128) check("init_done_rise", 16'(bus.init_done), 16'h0001);
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_douta", bus.douta, 16'h0000);
    check("rst_doutb", bus.doutb, 16'h0000);
    check("rst_init_done", 16'(bus.init_done), 16'h0000);
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    sweep();
  endtask

  task automatic random_traffic(input int n);
    logic ea, wa, eb, wb;
    logic [6:0] aa, ab;
    for (int i = 0; i < n; i++) begin
      ea = ($urandom_range(0, 3) != 0);
      eb = ($urandom_range(0, 3) != 0);
      wa = $urandom_range(0, 1) == 1;
      wb = $urandom_range(0, 1) == 1;
      aa = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 3)) : 7'($urandom);
      ab = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 3)) : 7'($urandom);
      issue(ea, wa, aa, 16'($urandom), eb, wb, ab, 16'($urandom));
    end
  endtask

  initial begin
    bus.ena = 1'b0; bus.wea = 1'b0; bus.addra = '0; bus.dina = '0;
    bus.enb = 1'b0; bus.web = 1'b0; bus.addrb = '0; bus.dinb = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("por_douta", bus.douta, 16'h0000);
    check("por_doutb", bus.doutb, 16'h0000);
    check("por_init_done", 16'(bus.init_done), 16'h0000);
    sweep();

    issue(1, 0, 7'd0,   '0, 1, 0, 7'd64, '0);
    issue(1, 0, 7'd127, '0, 0, 0, 7'd0,  '0);

    issue(1, 1, 7'd7, 16'hBEEF, 0, 0, 7'd0, '0);
    issue(0, 0, 7'd0, '0,       1, 0, 7'd7, '0);

    issue(1, 1, 7'd5, 16'h1234, 1, 1, 7'd5, 16'h5678);
    issue(1, 0, 7'd5, '0,       1, 0, 7'd5, '0);

    issue(1, 1, 7'd9, 16'h0011, 0, 0, 7'd0, '0);
    issue(1, 1, 7'd9, 16'h00AA, 1, 0, 7'd9, '0);
    issue(0, 0, 7'd0, '0,       1, 0, 7'd9, '0);

    issue(0, 0, 7'd0, '0, 1, 0, 7'd7, '0);
    for (int i = 0; i < 5; i++) issue(0, 0, 7'd0, '0, 0, 1'(i), 7'd7, 16'($urandom));
    issue(1, 0, 7'd7, '0, 0, 0, 7'd0, '0);

    random_traffic(1500);
    issue(1, 1, 7'd7, 16'hBEEF, 1, 1, 7'd9, 16'h00AA);
    issue(1, 1, 7'd5, 16'h1234, 1, 0, 7'd7, '0);
    do_reset();

    issue(1, 0, 7'd7, '0, 1, 0, 7'd5, '0);
    issue(1, 0, 7'd9, '0, 1, 0, 7'd7, '0);
    random_traffic(500);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: got no completion expected finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
